// File: rtl/display_list_player.sv
// display_list_player
//   Display-list sequencer driving the vector control handshake. It walks a
//   sync-read RAM of 26-bit command words ([25:24] op, [23:12] y, [11:0] x)
//   and issues one jump/draw pulse per JUMP/DRAW word, gated by `ready`.
//   SHIFT words update the line-generator shift. HALT ends a frame, and in loop
//   mode the frame restarts at a minimum refresh period.
// Ports
//   clk, reset_n              clock, async active-low reset
//   start, stop, loop_en      control: start play / abort at boundary / repeat
//   mem_addr, mem_rdata       display-list RAM (data valid 1 cycle after addr)
//   ready                     control block accepting a command
//   x, y, jump, draw, shift   command outputs to the control block
//   busy, frame_done          status
module display_list_player #(
  parameter int ADDR_W       = 12,
  parameter int GUARD_CYCLES = 2,
  parameter int FRAME_CYCLES = 0,
  parameter int SHIFT_INIT   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [25:0]       mem_rdata,
  input  logic              ready,
  output logic [11:0]       x,
  output logic [11:0]       y,
  output logic              jump,
  output logic              draw,
  output logic [3:0]        shift,
  output logic              busy,
  output logic              frame_done
);

  localparam int GW = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;
  localparam int TW = $clog2(FRAME_CYCLES + 2);

  localparam logic [1:0] OP_JUMP  = 2'b00;
  localparam logic [1:0] OP_DRAW  = 2'b01;
  localparam logic [1:0] OP_SHIFT = 2'b10;
  localparam logic [1:0] OP_HALT  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_WAIT_RDY, S_FRAME_WAIT
  } state_t;

  state_t          state, state_n;
  logic [25:0]     pending;
  logic [GW-1:0]   guard;
  logic [TW-1:0]   timer;
  logic            stop_flag;
  logic            end_flag;   // last address issued: next decode becomes HALT

  logic            stop_any;
  logic            can_act;
  logic            frame_ok;
  logic            issue_j, issue_d, set_shift, halt_done, go_idle, frame_start;
  logic [1:0]      op;

  assign stop_any = stop_flag | stop;
  assign op       = pending[25:24];
  assign can_act  = ready && (guard == '0);
  assign frame_ok = (FRAME_CYCLES == 0) || (int'(timer) >= FRAME_CYCLES - 1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n     = state;
    issue_j     = 1'b0;
    issue_d     = 1'b0;
    set_shift   = 1'b0;
    halt_done   = 1'b0;
    go_idle     = 1'b0;
    frame_start = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !stop) begin
          frame_start = 1'b1;
          state_n     = S_FETCH;
        end
      end
      S_FETCH:  state_n = S_DECODE;
      S_DECODE: state_n = S_WAIT_RDY;
      S_WAIT_RDY: begin
        if (can_act) begin
          if (stop_any) begin
            go_idle = 1'b1;
          end else begin
            case (op)
              OP_JUMP:  begin issue_j   = 1'b1; state_n = S_FETCH; end
              OP_DRAW:  begin issue_d   = 1'b1; state_n = S_FETCH; end
              OP_SHIFT: begin set_shift = 1'b1; state_n = S_FETCH; end
              default: begin
                halt_done = 1'b1;
                if (loop_en) state_n = S_FRAME_WAIT;
                else         go_idle = 1'b1;
              end
            endcase
          end
        end
      end
      S_FRAME_WAIT: begin
        if (stop_any) begin
          go_idle = 1'b1;
        end else if (frame_ok) begin
          frame_start = 1'b1;
          state_n     = S_FETCH;
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (go_idle) state_n = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr   <= '0;
      x          <= '0;
      y          <= '0;
      jump       <= 1'b0;
      draw       <= 1'b0;
      shift      <= 4'(SHIFT_INIT);
      busy       <= 1'b0;
      frame_done <= 1'b0;
      pending    <= '0;
      guard      <= '0;
      timer      <= '0;
      stop_flag  <= 1'b0;
      end_flag   <= 1'b0;
    end else begin
      jump       <= issue_j;
      draw       <= issue_d;
      frame_done <= halt_done;

      // Guard runs down through FETCH/DECODE so prefetch overlaps the dwell.
      if (issue_j || issue_d)  guard <= GW'(GUARD_CYCLES);
      else if (guard != '0)    guard <= guard - 1'b1;

      if (frame_start)                timer <= '0;
      else if (busy && (timer != '1)) timer <= timer + 1'b1;

      // A stop in IDLE is dropped; otherwise it sticks until a return to IDLE.
      if (state_n == S_IDLE) stop_flag <= 1'b0;
      else if (stop)         stop_flag <= 1'b1;

      if (frame_start) begin
        mem_addr <= '0;
        end_flag <= 1'b0;
        busy     <= 1'b1;
      end
      if (go_idle) busy <= 1'b0;

      if (state == S_DECODE)
        pending <= end_flag ? {OP_HALT, 24'd0} : mem_rdata;

      if (issue_j || issue_d) begin
        x <= pending[11:0];
        y <= pending[23:12];
      end
      if (set_shift) shift <= pending[3:0];

      // At the top address the address holds; the refetch decodes as HALT.
      if (issue_j || issue_d || set_shift) begin
        if (&mem_addr) end_flag <= 1'b1;
        else           mem_addr <= mem_addr + 1'b1;
      end
    end
  end

endmodule
